// File: rtl/clk_div_ctrl_if.sv
// Config handshake bundle for clk_div_ctrl.
// master drives cfg_valid/cfg_count; slave returns cfg_ready.
interface clk_div_ctrl_if #(
  parameter int WIDTH = 14
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_count;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable 50% clock divider with glitch-free count updates.
// Ports: clk_in, rst, run, cfg (slave), div_out, tick, busy, active_count.
module clk_div_ctrl #(
  parameter int WIDTH     = 14,
  parameter int DEF_COUNT = 6000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  clk_div_ctrl_if.slave    cfg,
  output logic             div_out,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] active_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] shadow;
  logic             pend;
  logic             term;
  logic             xfer;

  assign term = (state != IDLE)
              && (cnt == active_count);
  assign xfer = cfg.cfg_valid
              && cfg.cfg_ready;

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (run) state_nxt = RUN;
      RUN:   if (!run) state_nxt = DRAIN;
      // a renewed run request wins over
      // the final falling toggle
      DRAIN: begin
        if (run)
          state_nxt = RUN;
        else if (term && div_out)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    cfg.cfg_ready = !pend
                  && (state != DRAIN);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt          <= '0;
      div_out      <= 1'b0;
      tick         <= 1'b0;
      pend         <= 1'b0;
      shadow       <= '0;
      active_count <= WIDTH'(DEF_COUNT);
    end else begin
      tick <= 1'b0;
      if (state == IDLE) begin
        cnt     <= '0;
        div_out <= 1'b0;
        if (xfer)
          active_count <= cfg.cfg_count;
      end else begin
        if (term) begin
          cnt     <= '0;
          div_out <= !div_out;
          tick    <= 1'b1;
          // only a count already waiting is
          // swapped in; xfer needs !pend
          if (pend) begin
            active_count <= shadow;
            pend         <= 1'b0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (xfer) begin
          shadow <= cfg.cfg_count;
          pend   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl.
// Model predicts toggles; monitor checks tick and status.
module tb_clk_div_ctrl;
  localparam int W   = 14;
  localparam int DEF = 3;

  typedef struct {
    int cyc;
    bit out;
    int n;
  } exp_t;

  logic         clk = 0;
  logic         rst;
  logic         run;
  logic         div_out, tick, busy;
  logic [W-1:0] active_count;

  logic         drun = 0;
  logic         d_div, d_tick, d_busy;
  logic [W-1:0] d_act;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit armed  = 0;

  exp_t exp_q[$];
  int   pq[$];
  bit   m_on, m_stop, m_out;
  int   m_n, m_left;
  bit   m_rdy, m_xfer, was_high;
  exp_t e;

  clk_div_ctrl_if #(.WIDTH(W)) cif ();
  clk_div_ctrl_if #(.WIDTH(W)) dif ();

  clk_div_ctrl #(
    .WIDTH(W),
    .DEF_COUNT(DEF)
  ) u_dut (
    .clk_in(clk),
    .rst(rst),
    .run(run),
    .cfg(cif.slave),
    .div_out(div_out),
    .tick(tick),
    .busy(busy),
    .active_count(active_count)
  );

  clk_div_ctrl u_def (
    .clk_in(clk),
    .rst(rst),
    .run(drun),
    .cfg(dif.slave),
    .div_out(d_div),
    .tick(d_tick),
    .busy(d_busy),
    .active_count(d_act)
  );

  always #5 clk = ~clk;

  // Reference: each half period lasts n+1
  // cycles; counted down to the next toggle.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_on   = 0;
      m_stop = 0;
      m_out  = 0;
      m_n    = DEF;
      pq.delete();
      armed  = 1;
    end else if (armed) begin
      m_rdy  = (pq.size() == 0)
             && !(m_on && m_stop);
      m_xfer = cif.cfg_valid && m_rdy;
      if (!m_on) begin
        if (m_xfer) m_n = int'(cif.cfg_count);
        if (run) begin
          m_on   = 1;
          m_stop = 0;
          m_left = m_n + 1;
        end
      end else begin
        if (m_left == 1) begin
          was_high = m_out;
          m_out = !m_out;
          if (pq.size() != 0)
            m_n = pq.pop_front();
          m_left = m_n + 1;
          exp_q.push_back('{cyc, m_out, m_n});
          if (m_stop && !run && was_high) begin
            m_on   = 0;
            m_stop = 0;
          end
        end else begin
          m_left--;
        end
        if (m_xfer)
          pq.push_back(int'(cif.cfg_count));
        if (m_on) m_stop = !run;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (busy !== m_on
          || div_out !== m_out
          || int'(active_count) != m_n
          || cif.cfg_ready !==
             ((pq.size() == 0) && !(m_on && m_stop))) begin
        errors++;
        $display("FAIL status cyc=%0d busy=%b/%b div=%b/%b act=%0d/%0d rdy=%b",
                 cyc, busy, m_on, div_out, m_out,
                 active_count, m_n, cif.cfg_ready);
      end
      if (tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tick_spurious cyc=%0d got tick want none",
                   cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.out != div_out
              || e.n != int'(active_count)) begin
            errors++;
            $display("FAIL tick cyc=%0d/%0d div=%b/%b act=%0d/%0d",
                     cyc, e.cyc, div_out, e.out,
                     active_count, e.n);
          end
        end
      end else if (exp_q.size() != 0
                   && exp_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL tick_missing cyc=%0d got 0 want tick at %0d",
                 cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name,
                     input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               name, act, req);
    end
  endtask

  task automatic cfg_send(input int n);
    cif.cfg_valid = 1;
    cif.cfg_count = W'(n);
    step(1);
    cif.cfg_valid = 0;
  endtask

  initial begin
    rst = 1;
    run = 1;
    cif.cfg_valid = 0;
    cif.cfg_count = '0;
    dif.cfg_valid = 0;
    dif.cfg_count = '0;
    step(2);
    chk("rst_def_act", int'(d_act), 6000);
    chk("rst_def_rdy", int'(dif.cfg_ready), 1);
    chk("rst_def_busy", int'(d_busy), 0);
    chk("rst_def_div", int'(d_div), 0);
    chk("rst_def_tick", int'(d_tick), 0);
    chk("rst_act", int'(active_count), DEF);

    rst = 0;
    step(21);
    step(2);
    cfg_send(1);
    chk("pend_rdy", int'(cif.cfg_ready), 0);
    step(20);

    rst = 1;
    step(1);
    rst = 0;
    step(6);
    run = 0;
    step(12);
    run = 1;
    step(9);
    run = 0;
    step(12);

    run = 1;
    step(2);
    cfg_send(5);
    step(1);
    rst = 1;
    step(1);
    rst = 0;
    chk("rst_pend_act", int'(active_count), DEF);
    chk("rst_pend_rdy", int'(cif.cfg_ready), 1);
    step(20);

    run = 0;
    step(12);
    cfg_send(0);
    run = 1;
    step(10);
    run = 0;
    step(4);
    chk("div2_idle", int'(busy), 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) run = !run;
      cif.cfg_valid = ($urandom_range(0, 3) == 0);
      cif.cfg_count = W'($urandom_range(0, 6));
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 0;
    run = 0;
    cif.cfg_valid = 0;
    step(40);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
